referencia_step_ctrl: RTL and testbench

Sequencer that converts two raw push-buttons into single-cycle ENA/UP/DOWN step commands for the 8-bit up/down reference-angle counter (±5 per step).
- Synchronises and debounces the buttons.
- Issues one step per press, then auto-repeats while the button is held.
- Honours the counter's upper/lower limit flags.
- Sits between the board buttons and the counter in the servo-control top level.

---
 rtl/referencia_pkg.sv | 26 ++
 rtl/referencia_step_ctrl_step_timer.sv | 42 ++++
 rtl/referencia_step_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_referencia_step_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/referencia_pkg.sv
// Shared types and default timing for the reference-angle step sequencer.
package referencia_pkg;

    // Timer width; must hold the largest of the cycle counts below.
    localparam int TW = 25;

    // Default cycle counts for a 50 MHz clock.
    localparam int DEBOUNCE_CYC_DEF = 500000;    // 10 ms
    localparam int HOLD_CYC_DEF     = 25000000;  // 0.5 s
    localparam int REPEAT_CYC_DEF   = 5000000;   // 100 ms

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        STEP     = 3'd2,
        HOLD     = 3'd3,
        REPEAT   = 3'd4,
        RELEASE  = 3'd5
    } state_e;

    // A press is valid only when exactly one button is high.
    function automatic logic is_press(input logic su, input logic sd);
        return su ^ sd;
    endfunction

endpackage

// File: rtl/referencia_step_ctrl_step_timer.sv
// Loadable down-counter shared by every timed state of the step sequencer.
// done is registered and true exactly while the count equals 1, so the FSM
// can leave a state on "reaches 1" without the count ever wrapping.
module step_timer #(
    parameter int TW = 25
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic          done
);

    logic [TW-1:0] count_q, count_d;
    logic          done_q, done_d;

    // Next count: load wins, otherwise decrement and saturate at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - TW'(1);
        end
        done_d = (count_d == TW'(1));
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/referencia_step_ctrl.sv
// Push-button to step-command sequencer for the reference-angle counter.
// Synchronises both buttons, debounces a single press, emits one step, then
// auto-repeats while the button stays held, suppressing steps at the limits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no button pressed, waiting for exactly one button
// DEBOUNCE | one button seen, waiting for it to stay stable
// STEP     | single cycle: ENA (or LIMIT_HIT) is high
// HOLD     | first step done, waiting before auto-repeat starts
// REPEAT   | auto-repeating, waiting between steps
// RELEASE  | waiting for both buttons to stay low before rearming
module referencia_step_ctrl #(
    parameter int DEBOUNCE_CYC = referencia_pkg::DEBOUNCE_CYC_DEF,
    parameter int HOLD_CYC     = referencia_pkg::HOLD_CYC_DEF,
    parameter int REPEAT_CYC   = referencia_pkg::REPEAT_CYC_DEF,
    parameter int TW           = referencia_pkg::TW
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_UP,
    input  logic BTN_DOWN,
    input  logic LIM_OK_UP,
    input  logic LIM_OK_DOWN,
    output logic ENA,
    output logic UP,
    output logic DOWN,
    output logic LIMIT_HIT,
    output logic BUSY
);

    import referencia_pkg::*;

    localparam logic [TW-1:0] DEB_VAL = TW'(DEBOUNCE_CYC);
    localparam logic [TW-1:0] HLD_VAL = TW'(HOLD_CYC);
    localparam logic [TW-1:0] RPT_VAL = TW'(REPEAT_CYC);

    // Bit 1 carries the up button, bit 0 the down button.
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic       su, sd;

    state_e     state_q, state_d;
    logic       dir_q, dir_d;       // 1 = up
    logic       rpt_q, rpt_d;       // first step already issued for this press
    logic       ena_q, ena_d;
    logic       up_q, up_d;
    logic       down_q, down_d;
    logic       lh_q, lh_d;
    logic       busy_q, busy_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_done;

    logic       latched_btn;
    logic       other_btn;
    logic       lim_ok;
    logic       take_step;

    // Two-flop synchroniser inputs.
    always_comb begin
        sync1_d = {BTN_UP, BTN_DOWN};
        sync2_d = sync1_q;
    end

    // Synchroniser stages.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign su = sync2_q[1];
    assign sd = sync2_q[0];

    step_timer #(
        .TW (TW)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    // Next-state, timer control and next registered outputs.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rpt_d     = rpt_q;
        ena_d     = 1'b0;
        up_d      = 1'b0;
        down_d    = 1'b0;
        lh_d      = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = DEB_VAL;
        tmr_en    = 1'b0;
        take_step = 1'b0;

        latched_btn = dir_q ? su : sd;
        other_btn   = dir_q ? sd : su;
        lim_ok      = dir_q ? LIM_OK_UP : LIM_OK_DOWN;

        case (state_q)
            IDLE: begin
                if (is_press(su, sd)) begin
                    dir_d    = su;
                    tmr_load = 1'b1;
                    tmr_val  = DEB_VAL;
                    state_d  = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                tmr_en = 1'b1;
                if (!latched_btn || other_btn) begin
                    state_d = IDLE;
                end else if (tmr_done) begin
                    take_step = 1'b1;
                end
            end
            STEP: begin
                tmr_load = 1'b1;
                if (!rpt_q) begin
                    tmr_val = HLD_VAL;
                    rpt_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    tmr_val = RPT_VAL;
                    state_d = REPEAT;
                end
            end
            HOLD, REPEAT: begin
                tmr_en = 1'b1;
                if (!latched_btn || other_btn) begin
                    tmr_load = 1'b1;
                    tmr_val  = DEB_VAL;
                    state_d  = RELEASE;
                end else if (tmr_done) begin
                    take_step = 1'b1;
                end
            end
            RELEASE: begin
                if (su || sd) begin
                    tmr_load = 1'b1;
                    tmr_val  = DEB_VAL;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_done) begin
                        rpt_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The limit flag is sampled on the same edge that enters STEP, so the
        // step outputs are decided here and land together with the state.
        if (take_step) begin
            state_d = STEP;
            if (lim_ok) begin
                ena_d  = 1'b1;
                up_d   = dir_q;
                down_d = ~dir_q;
            end else begin
                lh_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // FSM state, latched direction, repeat flag and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            dir_q   <= 1'b1;
            rpt_q   <= 1'b0;
            ena_q   <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            lh_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rpt_q   <= rpt_d;
            ena_q   <= ena_d;
            up_q    <= up_d;
            down_q  <= down_d;
            lh_q    <= lh_d;
            busy_q  <= busy_d;
        end
    end

    assign ENA       = ena_q;
    assign UP        = up_q;
    assign DOWN      = down_q;
    assign LIMIT_HIT = lh_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_referencia_step_ctrl.sv
// Directed bench for referencia_step_ctrl with short timing parameters.
// Cycle k of a scenario is the k-th rising edge after start(); inputs set
// before tick k are sampled on that edge, and outputs are recorded 1 ns
// after it into per-cycle history vectors.
module tb_referencia_step_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic BTN_UP;
    logic BTN_DOWN;
    logic LIM_OK_UP;
    logic LIM_OK_DOWN;
    logic ENA;
    logic UP;
    logic DOWN;
    logic LIMIT_HIT;
    logic BUSY;

    int errors = 0;
    int checks = 0;
    int cyc    = -1;

    logic [63:0] ena_h, up_h, dn_h, lh_h, busy_h;

    referencia_step_ctrl #(
        .DEBOUNCE_CYC (4),
        .HOLD_CYC     (10),
        .REPEAT_CYC   (3),
        .TW           (25)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BTN_UP      (BTN_UP),
        .BTN_DOWN    (BTN_DOWN),
        .LIM_OK_UP   (LIM_OK_UP),
        .LIM_OK_DOWN (LIM_OK_DOWN),
        .ENA         (ENA),
        .UP          (UP),
        .DOWN        (DOWN),
        .LIMIT_HIT   (LIMIT_HIT),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (cyc >= 0 && cyc < 64) begin
            ena_h[cyc]  = ENA;
            up_h[cyc]   = UP;
            dn_h[cyc]   = DOWN;
            lh_h[cyc]   = LIMIT_HIT;
            busy_h[cyc] = BUSY;
        end
    endtask

    task automatic start();
        cyc    = -1;
        ena_h  = '0;
        up_h   = '0;
        dn_h   = '0;
        lh_h   = '0;
        busy_h = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST         = 1'b1;
        BTN_UP      = 1'b0;
        BTN_DOWN    = 1'b0;
        LIM_OK_UP   = 1'b1;
        LIM_OK_DOWN = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", 64'({ENA, UP, DOWN, LIMIT_HIT, BUSY}), 64'h0);
        RST = 1'b0;
        repeat (2) tick();

        // Single press: one up step at cycle 6, then release back to idle.
        start();
        BTN_UP = 1'b1;
        repeat (8) tick();
        BTN_UP = 1'b0;
        repeat (16) tick();
        chk("single_ena",   ena_h, 64'h40);
        chk("single_up",    up_h,  64'h40);
        chk("single_down",  dn_h,  64'h0);
        chk("single_limit", lh_h,  64'h0);
        chk("single_busy1", 64'(busy_h[1]),  64'h0);
        chk("single_busy2", 64'(busy_h[2]),  64'h1);
        chk("single_busy_end", 64'(busy_h[20]), 64'h0);

        // Hold down: steps at 6, 17, 21, 25, 29.
        start();
        BTN_DOWN = 1'b1;
        repeat (30) tick();
        BTN_DOWN = 1'b0;
        repeat (14) tick();
        chk("hold_ena",  ena_h, 64'h22220040);
        chk("hold_down", dn_h,  64'h22220040);
        chk("hold_up",   up_h,  64'h0);
        chk("hold_busy_end", 64'(busy_h[43]), 64'h0);

        // Bounce: up toggles every two cycles, never stable long enough.
        start();
        for (int k = 0; k < 12; k++) begin
            BTN_UP = ((k % 4) < 2);
            tick();
        end
        BTN_UP = 1'b0;
        repeat (10) tick();
        chk("bounce_ena",   ena_h, 64'h0);
        chk("bounce_limit", lh_h,  64'h0);
        chk("bounce_busy2", 64'(busy_h[2]),  64'h1);
        chk("bounce_busy4", 64'(busy_h[4]),  64'h0);
        chk("bounce_busy_end", 64'(busy_h[21]), 64'h0);

        // Limit: suppressed steps at 6, 17, 21; flag restored, step at 25.
        LIM_OK_UP = 1'b0;
        start();
        BTN_UP = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k == 24) LIM_OK_UP = 1'b1;
            if (k == 26) BTN_UP = 1'b0;
            tick();
        end
        repeat (10) tick();
        chk("limit_hit",  lh_h,  64'h220040);
        chk("limit_ena",  ena_h, 64'h2000000);
        chk("limit_up",   up_h,  64'h2000000);
        chk("limit_down", dn_h,  64'h0);

        // Both pressed: nothing until down released at 10, step at 16.
        start();
        BTN_UP   = 1'b1;
        BTN_DOWN = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) BTN_DOWN = 1'b0;
            if (k == 22) BTN_UP = 1'b0;
            tick();
        end
        repeat (10) tick();
        chk("both_ena",  ena_h, 64'h10000);
        chk("both_up",   up_h,  64'h10000);
        chk("both_busy5", 64'(busy_h[5]),  64'h0);
        chk("both_busy_end", 64'(busy_h[39]), 64'h0);

        // Reset during hold: outputs cleared, fresh debounce gives step at 20.
        start();
        BTN_UP = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 12) RST = 1'b1;
            if (k == 14) RST = 1'b0;
            if (k == 24) BTN_UP = 1'b0;
            tick();
        end
        repeat (10) tick();
        chk("rst_ena", ena_h, 64'h100040);
        chk("rst_up",  up_h,  64'h100040);
        chk("rst_outs12", 64'({ena_h[12], up_h[12], dn_h[12], lh_h[12], busy_h[12]}), 64'h0);
        chk("rst_outs13", 64'({ena_h[13], up_h[13], dn_h[13], lh_h[13], busy_h[13]}), 64'h0);
        chk("rst_busy15", 64'(busy_h[15]), 64'h0);
        chk("rst_busy16", 64'(busy_h[16]), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
